// File: rtl/time_source_gen_pkg.sv
// ----------------------------------------------------------------------------
// time_source_gen_pkg
// Shared definitions for the time source: packed time-word field widths,
// field maximum values, stopwatch state encoding, watch field-select encoding
// and a modulo step helper used for field adjust.
// ----------------------------------------------------------------------------
package time_source_gen_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CSEC_W = 7;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W + CSEC_W;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [CSEC_W-1:0] CSEC_MAX = 7'd99;

    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_RUN  = 2'd1,
        SW_STOP = 2'd2
    } sw_state_t;

    typedef enum logic [1:0] {
        FIELD_CSEC = 2'd0,
        FIELD_SEC  = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_HOUR = 2'd3
    } field_sel_t;

    // Step a field by +/-1 modulo (max_value + 1). Fields narrower than
    // 7 bits are passed zero-extended and truncated back by the caller.
    function automatic logic [6:0] step_mod(input logic [6:0] value,
                                            input logic [6:0] max_value,
                                            input logic       up);
        logic [6:0] result;
        if (up) begin
            result = (value == max_value) ? 7'd0 : value + 7'd1;
        end else begin
            result = (value == 7'd0) ? max_value : value - 7'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/time_source_gen_counter_chain.sv
// ----------------------------------------------------------------------------
// time_counter_chain
// One hour/min/sec/csec counter chain with full same-cycle carry, per-field
// adjust (no carry/borrow) and a synchronous clear that loads load_value.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (loads INIT_VALUE)
//   tick            advance the chain by one csec
//   adj_en          enables field adjust
//   field_sel       field to adjust (csec/sec/min/hour)
//   up, down        adjust step direction; both high means no adjust
//   clear           synchronous load of load_value, highest priority
//   load_value      packed value loaded by clear
//   time_data       packed {hour, min, sec, csec}
// ----------------------------------------------------------------------------
module time_counter_chain
    import time_source_gen_pkg::*;
#(
    parameter logic [TIME_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              adj_en,
    input  logic [1:0]        field_sel,
    input  logic              up,
    input  logic              down,
    input  logic              clear,
    input  logic [TIME_W-1:0] load_value,
    output logic [TIME_W-1:0] time_data
);

    logic [HOUR_W-1:0] hour, hour_next;
    logic [MIN_W-1:0]  min,  min_next;
    logic [SEC_W-1:0]  sec,  sec_next;
    logic [CSEC_W-1:0] csec, csec_next;
    logic              adjust;

    assign adjust = adj_en && (up ^ down);

    // An adjust takes the whole cycle: a coincident tick is dropped.
    always_comb begin
        hour_next = hour;
        min_next  = min;
        sec_next  = sec;
        csec_next = csec;
        if (clear) begin
            {hour_next, min_next, sec_next, csec_next} = load_value;
        end else if (adjust) begin
            case (field_sel)
                FIELD_CSEC: csec_next = CSEC_W'(step_mod(7'(csec), 7'(CSEC_MAX), up));
                FIELD_SEC:  sec_next  = SEC_W'(step_mod(7'(sec), 7'(SEC_MAX), up));
                FIELD_MIN:  min_next  = MIN_W'(step_mod(7'(min), 7'(MIN_MAX), up));
                default:    hour_next = HOUR_W'(step_mod(7'(hour), 7'(HOUR_MAX), up));
            endcase
        end else if (tick) begin
            if (csec == CSEC_MAX) begin
                csec_next = '0;
                if (sec == SEC_MAX) begin
                    sec_next = '0;
                    if (min == MIN_MAX) begin
                        min_next  = '0;
                        hour_next = (hour == HOUR_MAX) ? '0 : hour + 1'b1;
                    end else begin
                        min_next = min + 1'b1;
                    end
                end else begin
                    sec_next = sec + 1'b1;
                end
            end else begin
                csec_next = csec + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {hour, min, sec, csec} <= INIT_VALUE;
        end else begin
            hour <= hour_next;
            min  <= min_next;
            sec  <= sec_next;
            csec <= csec_next;
        end
    end

    assign time_data = {hour, min, sec, csec};

endmodule

// File: rtl/time_source_gen.sv
// ----------------------------------------------------------------------------
// time_source_gen
// Produces the packed 24-bit time word for the display path from either a
// stopwatch chain or a free-running watch chain.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_mode        0 = stopwatch on output, 1 = watch on output
//   i_run_stop    pulse, toggles stopwatch run/stop
//   i_clear       pulse, clears stopwatch when not running
//   i_set_en      level, enables watch field adjust
//   i_sel_field   watch field to adjust (0 csec, 1 sec, 2 min, 3 hour)
//   i_up, i_down  pulses, step the selected watch field
//   o_time_data   registered packed {hour, min, sec, csec}
//   o_running     high while the stopwatch is in RUN
//   o_tick        one-cycle pulse at each TICK_HZ tick
// ----------------------------------------------------------------------------
module time_source_gen
    import time_source_gen_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mode,
    input  logic              i_run_stop,
    input  logic              i_clear,
    input  logic              i_set_en,
    input  logic [1:0]        i_sel_field,
    input  logic              i_up,
    input  logic              i_down,
    output logic [TIME_W-1:0] o_time_data,
    output logic              o_running,
    output logic              o_tick
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [TIME_W-1:0] WATCH_INIT = {HOUR_W'(INIT_HOUR), 19'd0};

    logic [CNT_W-1:0]  tick_cnt;
    sw_state_t         state, state_next;
    logic              running;
    logic              sw_tick;
    logic              sw_clear;
    logic [TIME_W-1:0] sw_time;
    logic [TIME_W-1:0] watch_time;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign o_tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SW_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // run_stop takes priority over clear in every state.
    always_comb begin
        state_next = state;
        if (i_run_stop) begin
            case (state)
                SW_IDLE: state_next = SW_RUN;
                SW_RUN:  state_next = SW_STOP;
                SW_STOP: state_next = SW_RUN;
                default: state_next = SW_IDLE;
            endcase
        end else if (i_clear && state != SW_RUN) begin
            state_next = SW_IDLE;
        end
    end

    // The chain counts on the current state, so a tick landing on the
    // RUN->STOP edge is still counted.
    always_comb begin
        running  = (state == SW_RUN);
        sw_tick  = o_tick && (state == SW_RUN);
        sw_clear = i_clear && !i_run_stop && (state != SW_RUN);
    end

    assign o_running = running;

    time_counter_chain #(
        .INIT_VALUE ('0)
    ) u_stopwatch (
        .clk        (clk),
        .rst        (rst),
        .tick       (sw_tick),
        .adj_en     (1'b0),
        .field_sel  (2'b00),
        .up         (1'b0),
        .down       (1'b0),
        .clear      (sw_clear),
        .load_value ('0),
        .time_data  (sw_time)
    );

    time_counter_chain #(
        .INIT_VALUE (WATCH_INIT)
    ) u_watch (
        .clk        (clk),
        .rst        (rst),
        .tick       (o_tick),
        .adj_en     (i_set_en),
        .field_sel  (i_sel_field),
        .up         (i_up),
        .down       (i_down),
        .clear      (1'b0),
        .load_value (WATCH_INIT),
        .time_data  (watch_time)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_time_data <= '0;
        end else begin
            o_time_data <= i_mode ? watch_time : sw_time;
        end
    end

endmodule

// File: tb/tb_time_source_gen.sv
// ----------------------------------------------------------------------------
// tb_time_source_gen
// Directed bench for time_source_gen with CLK_FREQ = 1000, TICK_HZ = 100
// (tick every 10 cycles). Edge numbers in comments count clock edges after
// reset release; a watch tick lands on every edge that is a multiple of 10.
// ----------------------------------------------------------------------------
module tb_time_source_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mode;
    logic        i_run_stop;
    logic        i_clear;
    logic        i_set_en;
    logic [1:0]  i_sel_field;
    logic        i_up;
    logic        i_down;
    logic [23:0] o_time_data;
    logic        o_running;
    logic        o_tick;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    time_source_gen #(
        .CLK_FREQ  (1000),
        .TICK_HZ   (100),
        .INIT_HOUR (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (i_mode),
        .i_run_stop  (i_run_stop),
        .i_clear     (i_clear),
        .i_set_en    (i_set_en),
        .i_sel_field (i_sel_field),
        .i_up        (i_up),
        .i_down      (i_down),
        .o_time_data (o_time_data),
        .o_running   (o_running),
        .o_tick      (o_tick)
    );

    task automatic applyStimulus(input logic mode, input logic run_stop,
                                 input logic clear, input logic set_en,
                                 input logic [1:0] sel, input logic up,
                                 input logic down);
        i_mode      = mode;
        i_run_stop  = run_stop;
        i_clear     = clear;
        i_set_en    = set_en;
        i_sel_field = sel;
        i_up        = up;
        i_down      = down;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until o_tick is seen high (the tick lands on the next edge).
    task automatic waitTick(output int count);
        count = 0;
        do begin
            step(1);
            count++;
        end while (o_tick !== 1'b1 && count < 40);
        checkOutput("tick_wait", 24'(o_tick), 24'h1);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        #23;
        checkOutput("reset_time", o_time_data, 24'h000000);
        checkOutput("reset_running", 24'(o_running), 24'h0);
        checkOutput("reset_tick", 24'(o_tick), 24'h0);

        // Release with hour-down held: edges 1..12 take hour 12 -> 0 and
        // drop the tick on edge 10.
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        checkOutput("release_time", o_time_data, 24'h600000);
        checkOutput("release_tick", 24'(o_tick), 24'h0);
        step(11);
        i_down = 1'b0;
        step(1);
        checkOutput("hour_to_zero", o_time_data, 24'h000000);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        step(1);
        i_down = 1'b0;
        step(1);
        checkOutput("hour_wrap_down", o_time_data, 24'hB80000);

        // Edges 16..18: min, sec, csec each wrap down to their maximum.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        step(1);
        i_sel_field = 2'd1;
        step(1);
        i_sel_field = 2'd0;
        step(1);
        i_down = 1'b0;
        step(1);
        checkOutput("preload_23_59_59_99", o_time_data, 24'hBF7DE3);
        checkOutput("tick_at_edge19", 24'(o_tick), 24'h1);
        step(2);
        checkOutput("full_rollover", o_time_data, 24'h000000);

        // Edge 22 min up, edge 23 sec down -> 00:01:59.00.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step(1);
        i_down = 1'b0;
        step(1);
        checkOutput("sec_preload_59", o_time_data, 24'h003D80);
        i_up = 1'b1;
        step(1);
        i_up = 1'b0;
        step(1);
        checkOutput("sec_wrap_up", o_time_data, 24'h002000);

        i_up   = 1'b1;
        i_down = 1'b1;
        step(1);
        i_up   = 1'b0;
        i_down = 1'b0;
        step(1);
        checkOutput("up_down_both", o_time_data, 24'h002000);

        // Edge 30 ticks csec to 1; edge 40 carries a sec-up adjust on a tick.
        step(11);
        checkOutput("tick_at_edge39", 24'(o_tick), 24'h1);
        i_up = 1'b1;
        step(1);
        i_up = 1'b0;
        step(1);
        checkOutput("adjust_beats_tick", o_time_data, 24'h002081);

        waitTick(n);
        waitTick(n);
        checkOutput("tick_period", 24'(n), 24'd10);

        // Stopwatch: start, count 105 ticks, stop on the 105th tick edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1);
        checkOutput("sw_idle_time", o_time_data, 24'h000000);
        checkOutput("sw_idle_running", 24'(o_running), 24'h0);
        i_run_stop = 1'b1;
        step(1);
        i_run_stop = 1'b0;
        checkOutput("sw_run_running", 24'(o_running), 24'h1);
        for (int k = 0; k < 105; k++) begin
            waitTick(n);
        end
        checkOutput("sw_running_before_stop", 24'(o_running), 24'h1);
        i_run_stop = 1'b1;
        step(1);
        i_run_stop = 1'b0;
        checkOutput("sw_stop_running", 24'(o_running), 24'h0);
        step(1);
        checkOutput("sw_stop_1_05", o_time_data, 24'h000085);
        waitTick(n);
        waitTick(n);
        step(1);
        checkOutput("sw_stop_holds", o_time_data, 24'h000085);

        // Resume, then clear while running is ignored.
        i_run_stop = 1'b1;
        step(1);
        i_run_stop = 1'b0;
        checkOutput("sw_resume_running", 24'(o_running), 24'h1);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        checkOutput("sw_clear_in_run_running", 24'(o_running), 24'h1);
        waitTick(n);
        step(2);
        checkOutput("sw_clear_in_run_time", o_time_data, 24'h000086);

        // Stop, then clear in STOP returns to zero and IDLE.
        i_run_stop = 1'b1;
        step(1);
        i_run_stop = 1'b0;
        checkOutput("sw_stop2_running", 24'(o_running), 24'h0);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        step(1);
        checkOutput("sw_clear_in_stop_time", o_time_data, 24'h000000);
        checkOutput("sw_clear_in_stop_running", 24'(o_running), 24'h0);

        // run_stop and clear together from IDLE: run_stop wins.
        i_run_stop = 1'b1;
        i_clear    = 1'b1;
        step(1);
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        checkOutput("sw_both_running", 24'(o_running), 24'h1);
        waitTick(n);
        step(2);
        checkOutput("sw_restart_count", o_time_data, 24'h000001);

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midreset_time", o_time_data, 24'h000000);
        checkOutput("midreset_running", 24'(o_running), 24'h0);
        checkOutput("midreset_tick", 24'(o_tick), 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
